uart_rx: RTL

UART receive module: the receive end of the team's 8N1 serial link, paired with the transmitter on the same `tx` line. It synchronises the asynchronous `rx` line into the `clk` domain and detects the start bit, rejecting glitches. It samples 8 data bits LSB-first at mid-bit and checks the stop bit. It then presents the byte with a one-cycle `rx_done` strobe.

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver: two-flop synchroniser, glitch-rejecting start
// detect, mid-bit sampling LSB first, stop-bit check with break recovery.
module uart_rx #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int BIT  = clk_freq / baud_rate;
  localparam int HALF = BIT / 2;
  localparam int CW   = (BIT > 4) ? $clog2(BIT) : 2;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  generate
    if (BIT < 4) begin : g_bit_too_small
      $error("uart_rx: clk_freq/baud_rate must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          idx <= '0;
          if (!rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        // A start bit must still be low half a bit later, else it was a glitch.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            sh[idx] <= rx_s;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data <= sh;
              rx_done <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= RECOVER;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Framing was lost: only a high line re-arms start detection.
        RECOVER: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
